// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the mem_copy_dma initiator.
package dma_pkg;
    typedef enum logic [2:0] {IDLE, RD, RD_REL, WR, WR_REL} state_e;
    localparam logic [3:0] MASK_ALL = 4'b1111;
    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: counts consecutive wait cycles of one bus access and flags expiry.
// expired is combinational so the FSM can leave on the TIMEOUT-th wait cycle.
module bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear ? '0 : enable ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign expired = (TIMEOUT != 0) && enable && (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: bus initiator copying a block of 32-bit words from src to dst,
// one read then one write per word, with abort and per-access timeout.
module mem_copy_dma
    import dma_pkg::*;
#(
    parameter int COUNT_WIDTH = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start_in,
    input  logic                   abort_in,
    input  logic [31:0]            src_addr_in,
    input  logic [31:0]            dst_addr_in,
    input  logic [COUNT_WIDTH-1:0] word_count_in,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   error_out,
    output logic [31:0]            address_out,
    output logic                   sel_out,
    output logic [3:0]             write_mask_out,
    output logic [31:0]            write_value_out,
    input  logic [31:0]            read_value_in,
    input  logic                   ready_in
);
    state_e state_q, state_d;
    logic [31:0] src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d, rd_buf_q, rd_buf_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic error_q, error_d, done_q, done_d;
    logic wd_enable, wd_expired;

    assign wd_enable = sel_out && !ready_in;

    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!wd_enable),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        remaining_d = remaining_q;
        rd_buf_d = rd_buf_q;
        error_d = error_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    error_d = 1'b0;
                    if (word_count_in == '0) begin
                        done_d = 1'b1;
                    end else begin
                        src_ptr_d = word_align(src_addr_in);
                        dst_ptr_d = word_align(dst_addr_in);
                        remaining_d = word_count_in;
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (ready_in) begin
                    rd_buf_d = read_value_in;
                    state_d = RD_REL;
                end
            end
            RD_REL: state_d = WR;
            WR: state_d = ready_in ? WR_REL : WR;
            WR_REL: begin
                src_ptr_d = src_ptr_q + WORD_BYTES;
                dst_ptr_d = dst_ptr_q + WORD_BYTES;
                remaining_d = remaining_q - COUNT_WIDTH'(1);
                done_d = (remaining_q == COUNT_WIDTH'(1));
                state_d = done_d ? IDLE : RD;
            end
            default: state_d = IDLE;
        endcase
        // abort beats a same-cycle completion and leaves all datapath state untouched
        if (state_q != IDLE && (abort_in || wd_expired)) begin
            state_d = IDLE;
            src_ptr_d = src_ptr_q;
            dst_ptr_d = dst_ptr_q;
            remaining_d = remaining_q;
            rd_buf_d = rd_buf_q;
            error_d = abort_in ? error_q : 1'b1;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            remaining_q <= '0;
            rd_buf_q <= '0;
            error_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            remaining_q <= remaining_d;
            rd_buf_q <= rd_buf_d;
            error_q <= error_d;
            done_q <= done_d;
        end
    end

    assign sel_out = (state_q == RD) || (state_q == WR);
    assign address_out = state_q == RD ? src_ptr_q : state_q == WR ? dst_ptr_q : '0;
    assign write_mask_out = state_q == WR ? MASK_ALL : MASK_NONE;
    assign write_value_out = state_q == WR ? rd_buf_q : '0;
    assign busy_out = state_q != IDLE;
    assign done_out = done_q;
    assign error_out = error_q;
endmodule
